// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating counter predictor with a tagged branch target buffer.
// Lookup is combinational on if_pc; training from the ID-stage branch resolution is registered.
module branch_predictor #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   // Valid bits and counters are flops so reset can clear every entry in one cycle.
   logic [ENTRIES-1:0] r_valid;
   logic [1:0]         r_ctr    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];

   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;
   logic [IDX_W-1:0] w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic             w_upd_hit;
   logic [1:0]       w_ctr_cur;
   logic [1:0]       w_ctr_inc;
   logic [1:0]       w_ctr_dec;
   logic             w_unused_pc_bits;

   assign w_if_idx  = if_pc[IDX_W+1:2];
   assign w_if_tag  = if_pc[31:IDX_W+2];
   assign w_upd_idx = upd_pc[IDX_W+1:2];
   assign w_upd_tag = upd_pc[31:IDX_W+2];
   assign w_unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   assign w_if_hit  = r_valid[w_if_idx]  && (r_tag[w_if_idx]  == w_if_tag);
   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   // Lookup sees pre-update state; there is deliberately no bypass from the update port.
   assign pred_taken   = w_if_hit && r_ctr[w_if_idx][1];
   assign pred_target  = w_if_hit ? r_target[w_if_idx] : 32'd0;
   assign pred_next_pc = pred_taken ? pred_target : (if_pc + 32'd4);

   assign w_ctr_cur = r_ctr[w_upd_idx];
   assign w_ctr_inc = (w_ctr_cur == 2'b11) ? w_ctr_cur : (w_ctr_cur + 2'd1);
   assign w_ctr_dec = (w_ctr_cur == 2'b00) ? w_ctr_cur : (w_ctr_cur - 2'd1);

   // upd_valid is a single-cycle strobe with no back-pressure: an update is consumed
   // on the edge where it is high, unless rst is also high, in which case it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         if (w_upd_hit) begin
            r_ctr[w_upd_idx] <= upd_taken ? w_ctr_inc : w_ctr_dec;
         end else if (upd_taken) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_ctr[w_upd_idx]   <= 2'b10;
         end
      end
   end

   // Any taken update either refreshes a hit entry or allocates over the old occupant;
   // on a hit the tag rewrite is a no-op, so tag and target share one write enable.
   always_ff @(posedge clk) begin
      if (!rst && upd_valid && upd_taken) begin
         r_tag[w_upd_idx]    <= w_upd_tag;
         r_target[w_upd_idx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic,
// checked against an array-based model of the predictor rules.
module tb_branch_predictor;

   localparam int IDX_W = 6;
   localparam int NENT  = 1 << IDX_W;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;

   int total = 0;
   int bad   = 0;

   // {pc, taken, target, next_pc}
   logic [96:0] exp_q[$];

   bit          m_known = 0;
   bit          m_valid  [NENT];
   int unsigned m_tag    [NENT];
   logic [31:0] m_target [NENT];
   int          m_ctr    [NENT];

   branch_predictor #(.IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_next_pc(pred_next_pc), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc >> 2) % NENT;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   // Apply whatever is currently driven as if the edge just sampled it.
   task automatic model_edge();
      int unsigned u;
      bit hit;
      if (rst) begin
         for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
         end
         m_known = 1;
      end else if (m_known && upd_valid) begin
         u   = idx_of(upd_pc);
         hit = m_valid[u] && (m_tag[u] == tag_of(upd_pc));
         if (hit) begin
            if (upd_taken) begin
               m_ctr[u]    = (m_ctr[u] + 1 > 3) ? 3 : m_ctr[u] + 1;
               m_target[u] = upd_target;
            end else begin
               m_ctr[u] = (m_ctr[u] - 1 < 0) ? 0 : m_ctr[u] - 1;
            end
         end else if (upd_taken) begin
            m_valid[u]  = 1;
            m_tag[u]    = tag_of(upd_pc);
            m_target[u] = upd_target;
            m_ctr[u]    = 2;
         end
      end
   endtask

   function automatic logic [96:0] model_lookup(input logic [31:0] pc);
      int unsigned i;
      bit hit;
      logic tk;
      logic [31:0] tgt;
      logic [31:0] nxt;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      tk  = hit && (m_ctr[i] >= 2);
      tgt = hit ? m_target[i] : 32'd0;
      nxt = pc + 32'd4;
      if (tk) nxt = tgt;
      return {pc, tk, tgt, nxt};
   endfunction

   task automatic step(input logic r, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic [31:0] ipc);
      @(posedge clk);
      #1;
      model_edge();
      rst        = r;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_target = utgt;
      if_pc      = ipc;
      if (m_known) exp_q.push_back(model_lookup(ipc));
   endtask

   task automatic look(input logic [31:0] ipc);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, ipc);
   endtask

   task automatic train(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic [31:0] ipc);
      step(1'b0, 1'b1, upc, ut, utgt, ipc);
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'h0040_0000 + ($urandom_range(0, 2) << (IDX_W + 2)) + ($urandom_range(0, 3) << 2);
   endfunction

   always @(negedge clk) begin
      logic [96:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (pred_taken !== e[64]) begin
            bad++;
            $display("FAIL pred_taken pc=%h got=%b want=%b", e[96:65], pred_taken, e[64]);
         end
         total++;
         if (pred_target !== e[63:32]) begin
            bad++;
            $display("FAIL pred_target pc=%h got=%h want=%h", e[96:65], pred_target, e[63:32]);
         end
         total++;
         if (pred_next_pc !== e[31:0]) begin
            bad++;
            $display("FAIL pred_next_pc pc=%h got=%h want=%h", e[96:65], pred_next_pc, e[31:0]);
         end
      end
   end

   initial begin
      rst = 1; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; if_pc = 32'h0040_0000;

      // reset, including a lookup while still in reset
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0040_0000);
      look(32'h0040_0000);

      // allocation with same-cycle lookup, then visible next cycle
      train(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0010);
      look(32'h0040_0010);

      // saturate up, hysteresis, saturate down
      for (int k = 0; k < 3; k++) train(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0010);
      look(32'h0040_0010);
      for (int k = 0; k < 4; k++) begin
         train(32'h0040_0010, 1'b0, 32'h0040_0100, 32'h0040_0010);
         look(32'h0040_0010);
      end
      train(32'h0040_0010, 1'b1, 32'h0040_0200, 32'h0040_0010);
      look(32'h0040_0010);

      // aliasing on index 4
      train(32'h0040_0010, 1'b1, 32'h0040_0100, 32'h0040_0000);
      train(32'h0040_1010, 1'b1, 32'h0040_2000, 32'h0040_0010);
      look(32'h0040_0010);
      look(32'h0040_1010);

      // not-taken miss never allocates; later taken update does
      train(32'h0040_0020, 1'b0, 32'h0040_0300, 32'h0040_0020);
      look(32'h0040_0020);
      train(32'h0040_0020, 1'b0, 32'h0040_0300, 32'h0040_0020);
      train(32'h0040_0020, 1'b1, 32'h0040_0300, 32'h0040_0020);
      look(32'h0040_0020);

      // reset priority over a simultaneous update
      step(1'b1, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_0400, 32'h0040_0030);
      look(32'h0040_0030);
      look(32'h0040_0010);

      // next-pc wrap, then a taken branch at the top of memory
      look(32'hFFFF_FFFC);
      train(32'hFFFF_FFFC, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC);
      look(32'hFFFF_FFFC);

      // random traffic over a small PC pool to force hits, aliasing and saturation
      for (int k = 0; k < 400; k++) begin
         logic [31:0] upc;
         upc = rand_pc();
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), upc,
              ($urandom_range(0, 2) != 0), ($urandom & 32'hFFFF_FFFC),
              ($urandom_range(0, 1) == 1) ? upc : rand_pc());
      end

      look(32'h0040_0000);
      repeat (2) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the IF stage of the pipelined CPU: a direct-mapped table of 2-bit saturating counters combined with a tagged branch target buffer. Each cycle it looks up the fetch PC and supplies a predicted next PC. It is trained by the branch resolution result (`is_branch`, target) produced in ID by the branch comparator. Prediction is combinational; training is registered.

## Interface
- `IDX_W`, 6: index width; the table holds 2^IDX_W entries.
- `clk` input 1: system clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_pc` input 32: current fetch PC (word aligned).
- `pred_taken` output 1: lookup hit and predicted taken.
- `pred_next_pc` output 32: equals `pred_target` when `pred_taken` is 1, else `if_pc + 4`.
- `pred_target` output 32: stored target of the hit entry; 0 when there is no hit.
- `upd_valid` input 1: a conditional branch was resolved in ID this cycle.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_taken` input 1: resolved direction (the comparator's `is_branch`).
- `upd_target` input 32: resolved branch target.

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`. Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Lookup (combinational): hit = valid[idx] && tag[idx]==if_pc tag. pred_taken = hit && ctr[idx][1]. pred_target = hit ? target[idx] : 0.
- Counter states:
  - 00 strongly not-taken
  - 01 weakly not-taken
  - 10 weakly taken
  - 11 strongly taken
- Update, applied on the clock edge when `upd_valid`=1, with entry u = upd_pc index:
  - Tag match, taken: ctr increments and saturates at 11; target is overwritten with upd_target.
  - Tag match, not taken: ctr decrements and saturates at 00; target is unchanged.
  - Miss (invalid or tag mismatch), taken: allocate the entry. Set valid=1, tag=upd_pc tag, target=upd_target, ctr=10. Any previous occupant is evicted.
  - Miss, not taken: no state change. Not-taken branches never allocate.
- When `upd_valid`=0, no state changes.
- Reset: all valid bits cleared and all ctr set to 01 in the same cycle. Tags and targets are don't-care.
- Reset has priority over update. An update presented in a cycle where rst=1 is discarded.
- The block only predicts. Mispredict detection and pipeline flush are done by the caller, which compares pred_next_pc carried down the pipeline against the resolved PC.

## Timing
- Lookup latency is 0 cycles. Outputs are a pure function of `if_pc` and current state.
- An update becomes visible to lookup on the cycle after the edge that samples it.
- Same index looked up and updated in the same cycle: lookup returns the pre-update state. There is no bypass.
- Outputs during and after reset (all entries invalid): pred_taken=0, pred_target=0, pred_next_pc=if_pc+4.
- `if_pc + 4` wraps modulo 2^32: 0xFFFFFFFC gives 0x00000000.
- Aliasing: two PCs with the same index and different tags thrash one entry. That is allowed; there is no associativity.
- Storage may be flops or distributed RAM with asynchronous read. The full clear on reset requires the valid bits to be flops.

## Test plan
- Reset then lookup: rst for 1 cycle, if_pc=0x00400000 -> pred_taken=0, pred_target=0, pred_next_pc=0x00400004.
- Allocation: upd_valid=1, upd_pc=0x00400010, upd_taken=1, upd_target=0x00400100; next cycle if_pc=0x00400010 -> pred_taken=1, pred_next_pc=0x00400100 (ctr=10).
- Saturation and hysteresis: three further taken updates on 0x00400010 take ctr to 11 and hold it there. Then one not-taken update -> pred_taken still 1. A second not-taken update -> pred_taken=0, pred_next_pc=0x00400014. Two more not-taken updates -> ctr holds at 00.
- Aliasing with IDX_W=6: after allocating 0x00400010, a taken update for 0x00401010 (same index, different tag) -> lookup of 0x00400010 gives pred_taken=0; lookup of 0x00401010 hits with the new target.
- Not-taken miss: upd_pc=0x00400020, upd_taken=0 on an empty entry -> next cycle lookup gives pred_taken=0 and the entry is still invalid (a later taken update allocates it with ctr=10).
- Same-cycle lookup/update and reset priority: if_pc equals upd_pc during an allocating update -> that cycle pred_taken=0, the next cycle 1. An update presented together with rst=1 -> no entry allocated after reset.
